// File: rtl/spi_master_if.sv
// spi_master_if: host-side command/response bus of the SPI master
interface spi_master_if #(
   parameter int FRAME_WIDTH = 8,
   parameter int CTRL_WIDTH  = 2
);
   localparam int CMD_WIDTH = FRAME_WIDTH + CTRL_WIDTH;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [CMD_WIDTH-1:0]   cmd_data;
   logic                   rsp_valid;
   logic [FRAME_WIDTH-1:0] rsp_data;
   logic                   busy;
   modport master (output cmd_valid, cmd_data, input cmd_ready, rsp_valid, rsp_data, busy);
   modport slave  (input cmd_valid, cmd_data, output cmd_ready, rsp_valid, rsp_data, busy);
endinterface

// File: rtl/spi_master.sv
// spi_master: frames host commands onto SS_n/MOSI and captures read replies from MISO
module spi_master #(
   parameter int FRAME_WIDTH = 8,
   parameter int CTRL_WIDTH  = 2,
   parameter int CMD_WIDTH   = FRAME_WIDTH + CTRL_WIDTH,
   parameter int MISO_DELAY  = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   spi_master_if.slave bus,
   output logic        o_ss_n,
   output logic        o_mosi,
   input  logic        i_miso
);
   localparam int CNT_MAX0 = (CMD_WIDTH > MISO_DELAY) ? CMD_WIDTH : MISO_DELAY;
   localparam int CNT_MAX  = (CNT_MAX0 > FRAME_WIDTH) ? CNT_MAX0 : FRAME_WIDTH;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CMD_WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(MISO_DELAY - 2);
   localparam logic [CNT_W-1:0] LAST_CAPT  = CNT_W'(FRAME_WIDTH - 1);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SELECT  = 3'd1;
   localparam logic [2:0] S_CMD     = 3'd2;
   localparam logic [2:0] S_SHIFT   = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;
   localparam logic [2:0] S_CAPTURE = 3'd5;

   logic [2:0]             r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CMD_WIDTH-1:0]   r_tx;
   logic [CTRL_WIDTH-1:0]  r_ctrl;
   logic [FRAME_WIDTH-1:0] r_rx, r_rsp_data, w_rx_nxt;
   logic                   r_rsp_valid, r_ss_n, r_mosi;
   logic                   w_accept, w_rd, w_done;

   assign w_accept      = bus.cmd_valid & (r_state == S_IDLE);
   assign w_rd          = (r_ctrl == {CTRL_WIDTH{1'b1}});
   assign w_rx_nxt      = {r_rx[FRAME_WIDTH-2:0], i_miso};
   assign w_done        = (r_state == S_CAPTURE) & (r_cnt == LAST_CAPT);
   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign o_ss_n        = r_ss_n;
   assign o_mosi        = r_mosi;

   // next state: fixed-length phases, read-data frames append wait and capture
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    w_state_nxt = w_accept ? S_SELECT : S_IDLE;
         S_SELECT:  w_state_nxt = S_CMD;
         S_CMD:     w_state_nxt = S_SHIFT;
         S_SHIFT:   w_state_nxt = (r_cnt != LAST_SHIFT) ? S_SHIFT :
                                  !w_rd ? S_IDLE : (MISO_DELAY > 1) ? S_WAIT : S_CAPTURE;
         S_WAIT:    w_state_nxt = (r_cnt == LAST_WAIT) ? S_CAPTURE : S_WAIT;
         S_CAPTURE: w_state_nxt = (r_cnt == LAST_CAPT) ? S_IDLE : S_CAPTURE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // state register; phase counter restarts at zero on every state entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (r_state == S_IDLE || w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
      end
   end

   // latch the command on accept, shift it out MSB first, gather the reply
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx        <= '0;
         r_ctrl      <= '0;
         r_rx        <= '0;
         r_rsp_data  <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_tx   <= bus.cmd_data;
            r_ctrl <= bus.cmd_data[CMD_WIDTH-1 -: CTRL_WIDTH];
         end else if (r_state == S_CMD || r_state == S_SHIFT) begin
            r_tx <= r_tx << 1;
         end
         if (r_state == S_CAPTURE) r_rx <= w_rx_nxt;
         if (w_done) r_rsp_data <= w_rx_nxt;
         r_rsp_valid <= w_done;
      end
   end

   // pins are registered from the upcoming state so they line up with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ss_n <= 1'b1;
         r_mosi <= 1'b0;
      end else begin
         r_ss_n <= (w_state_nxt == S_IDLE);
         r_mosi <= (w_state_nxt == S_CMD || w_state_nxt == S_SHIFT) & r_tx[CMD_WIDTH-1];
      end
   end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed and random frames on two builds (MISO_DELAY 3 and 1) against a frame-level model
module tb_spi_master;
   logic       clk = 1'b0;
   logic       rst_n, cv, sel, miso;
   logic [9:0] cd;
   logic       ss0, ss1, mo0, mo1;
   logic       ss_n, mosi, busy, rdy, rv;
   logic [7:0] rdata;
   logic [7:0] last_rsp [2];
   int         checks = 0;
   int         errors = 0;

   spi_master_if #(.FRAME_WIDTH(8), .CTRL_WIDTH(2)) bus0 ();
   spi_master_if #(.FRAME_WIDTH(8), .CTRL_WIDTH(2)) bus1 ();

   spi_master #(.MISO_DELAY(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus0), .o_ss_n(ss0), .o_mosi(mo0), .i_miso(miso));
   spi_master #(.MISO_DELAY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .o_ss_n(ss1), .o_mosi(mo1), .i_miso(miso));

   assign bus0.cmd_valid = cv & ~sel;
   assign bus1.cmd_valid = cv & sel;
   assign bus0.cmd_data  = cd;
   assign bus1.cmd_data  = cd;
   assign ss_n  = sel ? ss1 : ss0;
   assign mosi  = sel ? mo1 : mo0;
   assign busy  = sel ? bus1.busy : bus0.busy;
   assign rdy   = sel ? bus1.cmd_ready : bus0.cmd_ready;
   assign rv    = sel ? bus1.rsp_valid : bus0.rsp_valid;
   assign rdata = sel ? bus1.rsp_data : bus0.rsp_data;

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // MOSI seen by the slave in cycle t after accept: idle bit, rd/wr bit, then the frame MSB first
   function automatic logic exp_mosi(input logic [9:0] c, input int t);
      return (t == 1) ? c[9] : (t >= 2 && t <= 11) ? c[11-t] : 1'b0;
   endfunction

   // one complete frame; returns positioned in the first IDLE cycle after it
   task automatic frame(input logic s, input logic [9:0] cmd, input logic [7:0] reply, input int inj);
      bit rd;
      int d, len;
      sel = s;
      rd  = (cmd[9:8] == 2'b11);
      d   = s ? 1 : 3;
      len = rd ? 19 + d : 12;
      chk("ready_before", rdy, 1);
      cv = 1'b1;
      cd = cmd;
      @(negedge clk);
      cv = 1'b0;
      cd = 10'($urandom);
      for (int t = 0; t < len; t++) begin
         chk("ss_n_low", ss_n, 0);
         chk("mosi", mosi, exp_mosi(cmd, t));
         chk("busy_high", busy, 1);
         chk("ready_low", rdy, 0);
         chk("rsp_valid_mid", rv, 0);
         miso = (rd && t >= 11 + d) ? reply[7-(t-11-d)] : 1'($urandom);
         if (t == inj) begin
            cv = 1'b1;
            cd = 10'($urandom);
         end else begin
            cv = 1'b0;
         end
         @(negedge clk);
      end
      cv = 1'b0;
      if (rd) last_rsp[s] = reply;
      chk("ss_n_end", ss_n, 1);
      chk("mosi_end", mosi, 0);
      chk("busy_end", busy, 0);
      chk("ready_end", rdy, 1);
      chk("rsp_valid_end", rv, rd);
      chk("rsp_data_end", rdata, last_rsp[s]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("idle_ss_n", ss_n, 1);
         chk("idle_mosi", mosi, 0);
         chk("idle_busy", busy, 0);
         chk("idle_rsp_valid", rv, 0);
         chk("idle_rsp_data", rdata, last_rsp[sel]);
      end
   endtask

   initial begin
      logic [9:0] c;
      rst_n = 1'b0;
      cv = 1'b0;
      cd = '0;
      miso = 1'b0;
      sel = 1'b0;
      last_rsp[0] = 8'h00;
      last_rsp[1] = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_ss_n0", ss0, 1);
      chk("rst_mosi0", mo0, 0);
      chk("rst_rv0", bus0.rsp_valid, 0);
      chk("rst_rdata0", bus0.rsp_data, 0);
      chk("rst_busy0", bus0.busy, 0);
      chk("rst_ready0", bus0.cmd_ready, 1);
      chk("rst_ss_n1", ss1, 1);
      chk("rst_rdata1", bus1.rsp_data, 0);
      rst_n = 1'b1;
      idle(1);
      frame(0, 10'b00_1010_0101, 8'h00, -1);
      idle(2);
      frame(0, 10'b11_0011_1100, 8'hC3, -1);
      idle(1);
      frame(0, 10'b01_1111_0000, 8'h00, -1);
      frame(0, 10'b10_0000_0001, 8'h00, -1);
      idle(1);
      frame(0, 10'b11_1001_0110, 8'h96, 6);
      idle(3);
      sel = 1'b0;
      c = 10'b11_0100_1101;
      cv = 1'b1;
      cd = c;
      @(negedge clk);
      cv = 1'b0;
      repeat (5) @(negedge clk);
      chk("t5_ss_n", ss_n, 0);
      chk("t5_mosi", mosi, c[6]);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ss_n", ss_n, 1);
      chk("arst_mosi", mosi, 0);
      chk("arst_busy", busy, 0);
      chk("arst_rsp_valid", rv, 0);
      chk("arst_rsp_data", rdata, 0);
      last_rsp[0] = 8'h00;
      last_rsp[1] = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      frame(0, 10'b11_0101_0101, 8'h3C, -1);
      idle(1);
      frame(1, 10'b11_0000_1111, 8'h5A, -1);
      idle(1);
      frame(1, 10'b00_1100_1100, 8'h00, 3);
      for (int i = 0; i < 10; i++) begin
         frame(1'($urandom), 10'($urandom), 8'($urandom), $urandom_range(0, 25));
         idle($urandom_range(0, 2));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-clock SPI master that drives the team's SPI slave frame protocol: slave-select, a command bit, then a {ctrl, data} frame shifted MSB-first on MOSI.
- For read-data frames (ctrl = 2'b11) it captures the FRAME_WIDTH-bit reply from MISO after a fixed turnaround.
- Sits between a host/CPU-side command port and the chip-level SPI pins.
- SCK is not generated: serial bits advance one per clk, and the slave samples on the same clk.

Parameters:
- FRAME_WIDTH, 8, data bits per frame and reply width.
- CTRL_WIDTH, 2, control bits prepended to the frame (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
- CMD_WIDTH, FRAME_WIDTH+CTRL_WIDTH, serial frame length.
- MISO_DELAY, 3, cycles from the last MOSI frame-bit cycle to the first MISO reply-bit cycle. Must be ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host presents a command.
- cmd_ready  out  1  high exactly while in IDLE. Accept occurs when cmd_valid & cmd_ready are both high at a clk edge.
- cmd_data  in  CMD_WIDTH  frame; top CTRL_WIDTH bits are ctrl.
- rsp_valid  out  1  one-cycle pulse, reply captured. No backpressure.
- rsp_data  out  FRAME_WIDTH  captured reply; holds until next capture.
- busy  out  1  high whenever state ≠ IDLE.
- SS_n  out  1  slave select, active low, registered.
- MOSI  out  1  serial data to slave, registered.
- MISO  in  1  serial data from slave, sampled at clk edge.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - state = IDLE, SS_n = 1, MOSI = 0, rsp_valid = 0.
  - rsp_data = 0; internal shift registers and counter = 0.
  - No partial rsp_valid is generated.
- On accept, cmd_data is latched; later changes on cmd_data are ignored. Let T0 be the cycle after the accept.
- States and transitions:
  - IDLE: SS_n = 1, MOSI = 0. On accept → SELECT.
  - SELECT (T0): SS_n = 0, MOSI = 0. Lets the slave leave its idle state. → CMD.
  - CMD (T1): MOSI = cmd_data[CMD_WIDTH-1], used by the slave as the rd/wr bit. → SHIFT.
  - SHIFT (T2..T(CMD_WIDTH+1)): MOSI = cmd_data[CMD_WIDTH-1-i] in cycle T(2+i), MSB first.
    - After the last bit: → IDLE if ctrl ≠ 2'b11, else → WAIT.
  - WAIT: SS_n = 0, MOSI = 0, lasts MISO_DELAY-1 cycles (zero cycles if MISO_DELAY = 1). → CAPTURE.
  - CAPTURE: FRAME_WIDTH consecutive cycles. Let L = CMD_WIDTH+1 (the last SHIFT cycle).
    - MISO is sampled at the end of cycles T(L+MISO_DELAY) .. T(L+MISO_DELAY+FRAME_WIDTH-1).
    - Bits are shifted into the reply MSB first.
    - → IDLE, with rsp_data updated and rsp_valid = 1 in the first IDLE cycle.
- SS_n low duration, defaults:
  - Write-type and rd-addr frames: CMD_WIDTH+2 = 12 cycles.
  - rd-data frames: CMD_WIDTH+2+MISO_DELAY-1+FRAME_WIDTH = 22 cycles.
- SS_n is high for at least 1 cycle (the IDLE cycle) between frames. A back-to-back accept in that IDLE cycle is legal.
- cmd_valid outside IDLE is ignored and not queued.
- busy deasserts in the same cycle SS_n returns high.
- Counter width is $clog2 of max(CMD_WIDTH, MISO_DELAY, FRAME_WIDTH)+1. Counters reset to 0 on every state entry.

Test Plan:
- Write address: accept cmd_data = 10'b00_1010_0101 → SS_n low 12 cycles, MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1. No rsp_valid.
- Read data with a slave model (memory latency 1 cycle), where the slave returns 8'hC3 → rsp_valid pulses once with rsp_data = 8'hC3, SS_n low 22 cycles.
- Back-to-back: write-data frame 10'b01_1111_0000, then immediately rd-addr 10'b10_0000_0001 → exactly 1 SS_n-high cycle between the frames, both bit streams correct.
- Reset mid-frame: assert rst_n = 0 at T5 of a rd-data frame → SS_n = 1 and MOSI = 0 immediately (asynchronously). No rsp_valid. A new command after release works normally.
- Ignored command: pulse cmd_valid with other data while busy → no effect on the MOSI stream, no extra frame.
- MISO_DELAY = 1 build: rd-data with reply 8'h5A → capture starts the cycle after the last frame bit; rsp_data = 8'h5A.
